ulaplus_pixel: RTL

Pixel back end for the video path: serialises screen bitmap/attribute bytes, drives the palette read addresses (`ink_addr`/`paper_addr`) consumed by the ULAplus palette RAM, samples the returned `ink`/`paper` bytes and produces the final RGB pixel. It handles two modes:
- ULAplus mode (`active`=1): colours come from the palette.
- Standard Spectrum mode: colours are built from attribute, bright and flash.

It sits between the screen fetcher and the video DAC, on the palette's read port.

---
 rtl/ulaplus_pixel.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ulaplus_pixel.sv
// ULAplus / Spectrum pixel back end: serialises bitmap bytes, drives the palette
// read addresses and turns the returned entries (or attribute colours) into RGB.
module ulaplus_pixel #(
  parameter int FLASH_BIT = 4
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       vsync,
  input  logic       active,
  input  logic       load,
  input  logic [7:0] bitmap,
  input  logic [7:0] attr,
  input  logic       border,
  input  logic [2:0] border_color,
  input  logic       blank,
  output logic [5:0] ink_addr,
  output logic [5:0] paper_addr,
  input  logic [7:0] ink,
  input  logic [7:0] paper,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [2:0] b
);

  logic [7:0]         shReg_q, shReg_d;
  logic               pix1_q, pix1_d;
  logic [7:0]         attr1_q, attr1_d;
  logic               border1_q, border1_d;
  logic [2:0]         bcol1_q, bcol1_d;
  logic               blank1_q, blank1_d;
  logic [5:0]         inkAddr_q, inkAddr_d;
  logic [5:0]         paperAddr_q, paperAddr_d;
  logic [2:0]         r_q, r_d, g_q, g_d, b_q, b_d;
  logic [FLASH_BIT:0] flashCnt_q, flashCnt_d;

  logic               flashPhase;
  logic [7:0]         entry;
  logic               inkOn;
  logic [2:0]         colIdx;
  logic [2:0]         level;

  assign flashPhase = flashCnt_q[FLASH_BIT];

  always_comb begin
    shReg_d   = shReg_q;
    pix1_d    = pix1_q;
    attr1_d   = attr1_q;
    border1_d = border1_q;
    bcol1_d   = bcol1_q;
    blank1_d  = blank1_q;
    if (ce) begin
      if (load) begin
        pix1_d  = bitmap[7];
        shReg_d = {bitmap[6:0], 1'b0};
        attr1_d = attr;
      end else begin
        pix1_d  = shReg_q[7];
        shReg_d = {shReg_q[6:0], 1'b0};
      end
      border1_d = border;
      bcol1_d   = border_color;
      blank1_d  = blank;
    end
  end

  // Addresses follow the stage-1 values being captured, so the palette has a
  // whole pixel period to answer before stage 2 samples ink/paper.
  always_comb begin
    inkAddr_d   = {attr1_d[7:6], 1'b0, attr1_d[2:0]};
    paperAddr_d = border1_d ? {3'b001, bcol1_d}
                            : {attr1_d[7:6], 1'b1, attr1_d[5:3]};
  end

  always_comb begin
    entry  = border1_q ? paper : (pix1_q ? ink : paper);
    inkOn  = pix1_q ^ (attr1_q[7] & flashPhase);
    colIdx = border1_q ? bcol1_q : (inkOn ? attr1_q[2:0] : attr1_q[5:3]);
    level  = (!border1_q && attr1_q[6]) ? 3'd7 : 3'd5;
    r_d    = 3'd0;
    g_d    = 3'd0;
    b_d    = 3'd0;
    if (!blank1_q) begin
      if (active) begin
        r_d = entry[4:2];
        g_d = entry[7:5];
        b_d = {entry[1], entry[0], entry[1] | entry[0]};
      end else begin
        r_d = colIdx[1] ? level : 3'd0;
        g_d = colIdx[2] ? level : 3'd0;
        b_d = colIdx[0] ? level : 3'd0;
      end
    end
  end

  always_comb begin
    flashCnt_d = flashCnt_q;
    if (vsync) flashCnt_d = flashCnt_q + (FLASH_BIT + 1)'(1);
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      shReg_q     <= 8'd0;
      pix1_q      <= 1'b0;
      attr1_q     <= 8'd0;
      border1_q   <= 1'b0;
      bcol1_q     <= 3'd0;
      blank1_q    <= 1'b0;
      inkAddr_q   <= 6'd0;
      paperAddr_q <= 6'd0;
      r_q         <= 3'd0;
      g_q         <= 3'd0;
      b_q         <= 3'd0;
      flashCnt_q  <= '0;
    end else begin
      shReg_q    <= shReg_d;
      pix1_q     <= pix1_d;
      attr1_q    <= attr1_d;
      border1_q  <= border1_d;
      bcol1_q    <= bcol1_d;
      blank1_q   <= blank1_d;
      flashCnt_q <= flashCnt_d;
      if (ce) begin
        inkAddr_q   <= inkAddr_d;
        paperAddr_q <= paperAddr_d;
        r_q         <= r_d;
        g_q         <= g_d;
        b_q         <= b_d;
      end
    end
  end

  assign ink_addr   = inkAddr_q;
  assign paper_addr = paperAddr_q;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;

endmodule
